// File: rtl/sseg_pkg.sv
// sseg_pkg: shared hex font table, segment bit indices and pin polarity helper for the 7-segment scan driver
package sseg_pkg;

    // Bit positions inside the {g,f,e,d,c,b,a} segment vector
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    typedef logic [6:0] seg_t;

    // Active-high glyphs, entry 0 at the right: 0 1 2 3 4 5 6 7 8 9 A b C d E F
    localparam seg_t [15:0] HEX_FONT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // Convert an active-high segment pattern to the level the pins need
    function automatic seg_t seg_drive(input seg_t lit, input logic act_low);
        return act_low ? ~lit : lit;
    endfunction

endpackage

// File: rtl/sseg_hex_font.sv
// sseg_hex_font: combinational nibble to active-high 7-segment glyph decode
module sseg_hex_font
    import sseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    seg_t glyph;

    // Full 16-entry lookup, so every nibble has a defined glyph; the output
    // is assembled through the named indices to pin down the port bit order
    always_comb begin
        glyph = HEX_FONT[nibble];
        seg   = {glyph[SEG_G], glyph[SEG_F], glyph[SEG_E], glyph[SEG_D],
                 glyph[SEG_C], glyph[SEG_B], glyph[SEG_A]};
    end

endmodule

// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: time-multiplexed N-digit hex 7-segment driver with tear-free update and guard time
// Optional feature: define SSEG_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 16,
    parameter bit SEG_ACT_LOW  = 1'b1,
    parameter bit AN_ACT_LOW   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    output logic [6:0]              segs,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int CW     = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam int DW     = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int DISP_W = 6 * NUM_DIGITS;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0] DIG_LAST = DW'(NUM_DIGITS - 1);

    // Scan position
    logic [CW-1:0]         div_cnt_q, div_cnt_d;
    logic [DW-1:0]         digit_q, digit_d;
    logic                  slot_end, wrap;
    // Display content, packed as {value, dp_in, blank}
    logic [DISP_W-1:0]     shadow_q, shadow_d;
    logic [DISP_W-1:0]     pending_q, pending_d;
    logic                  pend_vld_q, pend_vld_d;
    logic [4*NUM_DIGITS-1:0] sh_val;
    logic [NUM_DIGITS-1:0] sh_dp, sh_blank;
    // Output datapath
    logic [3:0]            cur_nib;
    logic [6:0]            cur_glyph;
    logic [NUM_DIGITS-1:0] lzb;
    logic [NUM_DIGITS-1:0] an_on;
    logic                  cur_dark;
    logic [6:0]            segs_q, segs_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_tick_q, frame_tick_d;

    assign sh_val   = shadow_q[DISP_W-1 -: 4*NUM_DIGITS];
    assign sh_dp    = shadow_q[2*NUM_DIGITS-1 -: NUM_DIGITS];
    assign sh_blank = shadow_q[NUM_DIGITS-1:0];
    assign cur_nib  = sh_val[digit_q*4 +: 4];

    sseg_hex_font u_font (
        .nibble (cur_nib),
        .seg    (cur_glyph)
    );

    // Scan position: divider runs through one slot, digit advances at slot end;
    // frame_tick is precomputed so the registered pulse lines up with the wrap cycle
    always_comb begin
        slot_end     = div_cnt_q == CNT_LAST;
        wrap         = slot_end && digit_q == DIG_LAST;
        div_cnt_d    = slot_end ? '0 : div_cnt_q + 1'b1;
        digit_d      = !slot_end ? digit_q : (wrap ? '0 : digit_q + 1'b1);
        frame_tick_d = div_cnt_d == CNT_LAST && digit_d == DIG_LAST;
    end

    // Load buffering: new content waits in pending and is only committed at frame
    // wrap; a load on the wrap cycle itself bypasses pending
    always_comb begin
        pending_d  = load ? {value, dp_in, blank} : pending_q;
        pend_vld_d = wrap ? 1'b0 : (load | pend_vld_q);
        shadow_d   = !wrap     ? shadow_q :
                     load       ? {value, dp_in, blank} :
                     pend_vld_q ? pending_q : shadow_q;
    end

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    // Leading-zero mask: walk down from the MSB digit until the first nonzero
    // nibble; digit 0 always stays visible
    always_comb begin
        logic seen;
        seen = 1'b0;
        lzb  = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            seen   = seen | (sh_val[4*i +: 4] != 4'h0);
            lzb[i] = !seen;
        end
    end
`else
    assign lzb = '0;
`endif

    // Next pin levels: decode current digit, hold anodes off in the guard window,
    // darken blanked digits, then apply pin polarity
    always_comb begin
        cur_dark = sh_blank[digit_q] | lzb[digit_q];
        an_on    = (int'(div_cnt_q) < GUARD_CYCLES) ? '0 : NUM_DIGITS'(1) << digit_q;
        an_d     = AN_ACT_LOW ? ~an_on : an_on;
        segs_d   = seg_drive(cur_dark ? 7'h00 : cur_glyph, SEG_ACT_LOW);
        dp_d     = SEG_ACT_LOW ^ (!cur_dark & sh_dp[digit_q]);
    end

    // State and output registers; reset drives every pin to its off level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q    <= '0;
            digit_q      <= '0;
            shadow_q     <= '0;
            pending_q    <= '0;
            pend_vld_q   <= 1'b0;
            segs_q       <= {7{SEG_ACT_LOW}};
            dp_q         <= SEG_ACT_LOW;
            an_q         <= {NUM_DIGITS{AN_ACT_LOW}};
            frame_tick_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            digit_q      <= digit_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            pend_vld_q   <= pend_vld_d;
            segs_q       <= segs_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign segs       = segs_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// tb_sseg_scan_driver: randomized scoreboard bench for sseg_scan_driver against a frame-level model
module tb_sseg_scan_driver;

    localparam int N  = 4;
    localparam int R  = 4;
    localparam int G  = 1;
    localparam int RN = N * R;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank = '0;
    logic [6:0]  segs;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    always #5 clk = ~clk;

    sseg_scan_driver #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (R),
        .GUARD_CYCLES (G),
        .SEG_ACT_LOW  (1'b1),
        .AN_ACT_LOW   (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .blank      (blank),
        .segs       (segs),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    int checks = 0;
    int errors = 0;

    // Expected pin word {frame_tick, dp, segs, an} for each clock edge
    logic [12:0] exp_q[$];
    logic [12:0] mon_e;

    // Model: position within the frame, content shown this frame, most recent load
    int          pos;
    logic [15:0] sh_v, lv;
    logic [3:0]  sh_d, sh_b, ld_d, lb;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h3F; 4'h1: glyph = 7'h06; 4'h2: glyph = 7'h5B; 4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66; 4'h5: glyph = 7'h6D; 4'h6: glyph = 7'h7D; 4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F; 4'h9: glyph = 7'h6F; 4'hA: glyph = 7'h77; 4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39; 4'hD: glyph = 7'h5E; 4'hE: glyph = 7'h79; default: glyph = 7'h71;
        endcase
    endfunction

    // Pins after the edge taken at frame position p with content (v,d,b)
    function automatic logic [12:0] expect_out(input int p, input logic [15:0] v,
                                               input logic [3:0] d, input logic [3:0] b);
        int dig;
        int cnt;
        logic dark;
        logic [3:0] an_e;
        logic [6:0] s;
        logic de;
        logic ft;
        dig  = p / R;
        cnt  = p % R;
        dark = b[dig];
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        if (dig > 0 && (v >> (4 * dig)) == 16'h0) dark = 1'b1;
`endif
        an_e = (cnt < G) ? 4'hF : ~(4'b0001 << dig);
        s    = dark ? 7'h7F : ~glyph(v[dig*4 +: 4]);
        de   = dark ? 1'b1 : ~d[dig];
        ft   = ((p + 1) % RN) == RN - 1;
        return {ft, de, s, an_e};
    endfunction

    task automatic model_reset();
        pos  = 0;
        sh_v = '0; sh_d = '0; sh_b = '0;
        lv   = '0; ld_d = '0; lb   = '0;
    endtask

    // Drive one clock worth of inputs (called at a negedge) and queue the expected response
    task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        load  = ld;
        value = v;
        dp_in = d;
        blank = b;
        exp_q.push_back(expect_out(pos, sh_v, sh_d, sh_b));
        if (ld) begin
            lv = v; ld_d = d; lb = b;
        end
        if (pos == RN - 1) begin
            sh_v = lv; sh_d = ld_d; sh_b = lb;
        end
        pos = (pos + 1) % RN;
        @(negedge clk);
    endtask

    function automatic logic [15:0] rand_val();
        logic [15:0] r;
        for (int i = 0; i < 4; i++)
            r[i*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        return r;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
    endtask

    task automatic idle_to(input int p);
        while (pos != p) idle(1);
    endtask

    task automatic chk_off(input string name);
        checks++;
        if ({frame_tick, dp, segs, an} !== {1'b0, 1'b1, 7'h7F, 4'hF}) begin
            errors++;
            $display("FAIL %s an=%b segs=%h dp=%b ft=%b required an=1111 segs=7f dp=1 ft=0",
                     name, an, segs, dp, frame_tick);
        end
    endtask

    // Monitor: every edge the DUT presents a new pin word; compare against the queue head
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                checks++;
                if ({frame_tick, dp, segs, an} !== mon_e) begin
                    errors++;
                    $display("FAIL scan t=%0t an=%b segs=%h dp=%b ft=%b required an=%b segs=%h dp=%b ft=%b",
                             $time, an, segs, dp, frame_tick, mon_e[3:0], mon_e[10:4], mon_e[11], mon_e[12]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        #1 chk_off("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        // Idle scan with reset content, frame_tick cadence
        idle(2 * RN + 3);
        // Directed: 12AF loaded at frame position 3
        idle_to(3);
        step(1'b1, 16'h12AF, 4'h0, 4'h0);
        idle(2 * RN);
        // Two loads in one frame: only the later one is ever shown
        idle_to(1);
        step(1'b1, 16'h1111, 4'h0, 4'h0);
        idle(3);
        step(1'b1, 16'h2222, 4'h0, 4'h0);
        idle(2 * RN);
        // Load exactly on the wrap cycle goes straight to the next frame
        idle_to(RN - 1);
        step(1'b1, 16'h00C0, 4'h0, 4'h0);
        idle(RN + 2);
        // Blank wins over dp on digit 2
        step(1'b1, 16'h8888, 4'b0100, 4'b0100);
        idle(2 * RN);
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0)
                step(1'b1, rand_val(), 4'($urandom), 4'($urandom) & 4'($urandom));
            else
                idle(1);
        end
        // Reset mid slot 2 with a load still pending
        idle_to(1);
        step(1'b1, 16'hBEEF, 4'hF, 4'h0);
        idle_to(2 * R + 1);
        #2 rst_n = 1'b0;
        #1 chk_off("async_reset_off");
        @(negedge clk);
        @(negedge clk);
        chk_off("reset_hold");
        rst_n = 1'b1;
        model_reset();
        idle(2 * RN + 2);
        load = 1'b0;
        @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
